msg_len_recorder: RTL and testbench

- Passive downstream monitor on an AXI-Stream link.
- Accumulates byte and beat counts across every beat of a message. On the tlast beat it writes one length record into a small FIFO.
- Records leave on a valid/ready side stream to the control/CSR logic.
- Never back-pressures the data stream. It only observes s_tvalid, s_tready, s_tlast and s_tkeep.

---
 rtl/msg_pkg.sv | 30 +++
 rtl/msg_len_fifo.sv | 57 +++++
 rtl/msg_len_recorder.sv | 120 ++++++++++++
 tb/tb_msg_len_recorder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared types and helpers for the AXI-Stream message length recorder.
// Record field width is fixed here so the FIFO and the top agree on one layout.
package msg_pkg;

  localparam int REC_CNT_BITS = 16;
  localparam int KEEP_MAX     = 64;
  localparam int POP_W        = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_MSG = 1'b1
  } msg_state_e;

  typedef struct packed {
    logic [REC_CNT_BITS-1:0] bytes;
    logic [REC_CNT_BITS-1:0] beats;
    logic                    ovf;
  } msg_len_rec_t;

  // Counts set lanes of a keep vector zero-extended to KEEP_MAX bits.
  function automatic logic [POP_W-1:0] popcount_keep(input logic [KEEP_MAX-1:0] tkeep);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      n = n + {{(POP_W-1){1'b0}}, tkeep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/msg_len_fifo.sv
// Small synchronous record FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module msg_len_fifo
  import msg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  msg_len_rec_t data_i,
  input  logic         pop_i,
  output msg_len_rec_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  msg_len_rec_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Storage is reset too so the head reads as an all-zero record after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/msg_len_recorder.sv
// Passive AXI-Stream monitor: accumulates byte/beat counts per message and
// queues one saturating length record per tlast beat.
module msg_len_recorder
  import msg_pkg::*;
#(
  parameter int NUM_COUNT_BITS = REC_CNT_BITS,
  parameter int TKEEP_WIDTH    = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_BITS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_tvalid,
  input  logic                      s_tready,
  input  logic                      s_tlast,
  input  logic [TKEEP_WIDTH-1:0]    s_tkeep,
  output logic                      m_len_tvalid,
  input  logic                      m_len_tready,
  output logic [NUM_COUNT_BITS-1:0] m_len_bytes,
  output logic [NUM_COUNT_BITS-1:0] m_len_beats,
  output logic                      m_len_ovf,
  output logic [DROP_CNT_BITS-1:0]  drop_count,
  output logic                      in_msg
);

  localparam int N = NUM_COUNT_BITS;

  msg_state_e          state_q, state_d;
  logic [N-1:0]        acc_bytes_q, acc_bytes_d;
  logic [N-1:0]        acc_beats_q, acc_beats_d;
  logic                acc_ovf_q, acc_ovf_d;
  logic [DROP_CNT_BITS-1:0] drop_q, drop_d;

  logic                beat;
  logic [POP_W-1:0]    beat_bytes;
  logic [N:0]          sum_bytes, sum_beats;
  logic [N-1:0]        sat_bytes, sat_beats;
  logic                new_ovf;
  logic                push, pop, fifo_full, fifo_empty;
  msg_len_rec_t        push_rec, head_rec;

  assign beat       = s_tvalid && s_tready;
  assign beat_bytes = popcount_keep(KEEP_MAX'(s_tkeep));
  assign sum_bytes  = {1'b0, acc_bytes_q} + (N+1)'(beat_bytes);
  assign sum_beats  = {1'b0, acc_beats_q} + 1'b1;
  assign sat_bytes  = sum_bytes[N] ? '1 : sum_bytes[N-1:0];
  assign sat_beats  = sum_beats[N] ? '1 : sum_beats[N-1:0];
  assign new_ovf    = acc_ovf_q || sum_bytes[N] || sum_beats[N];

  assign push_rec.bytes = sat_bytes;
  assign push_rec.beats = sat_beats;
  assign push_rec.ovf   = new_ovf;

  always_comb begin
    state_d     = state_q;
    acc_bytes_d = acc_bytes_q;
    acc_beats_d = acc_beats_q;
    acc_ovf_d   = acc_ovf_q;
    push        = 1'b0;
    if (beat) begin
      if (s_tlast) begin
        push        = 1'b1;
        state_d     = IDLE;
        acc_bytes_d = '0;
        acc_beats_d = '0;
        acc_ovf_d   = 1'b0;
      end else begin
        state_d     = IN_MSG;
        acc_bytes_d = sat_bytes;
        acc_beats_d = sat_beats;
        acc_ovf_d   = new_ovf;
      end
    end
  end

  assign pop = m_len_tvalid && m_len_tready;

  // A record is lost only when the FIFO is full and nothing leaves this cycle.
  always_comb begin
    drop_d = drop_q;
    if (push && fifo_full && !pop && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_bytes_q <= '0;
      acc_beats_q <= '0;
      acc_ovf_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_bytes_q <= acc_bytes_d;
      acc_beats_q <= acc_beats_d;
      acc_ovf_q   <= acc_ovf_d;
      drop_q      <= drop_d;
    end
  end

  msg_len_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_len_tvalid = !fifo_empty;
  assign m_len_bytes  = head_rec.bytes;
  assign m_len_beats  = head_rec.beats;
  assign m_len_ovf    = head_rec.ovf;
  assign drop_count   = drop_q;
  assign in_msg       = (state_q == IN_MSG);

endmodule

// File: tb/tb_msg_len_recorder.sv
// Directed bench for msg_len_recorder: inputs change on the falling edge,
// outputs are compared on the falling edge against hand-computed values.
module tb_msg_len_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0;
  logic [7:0]  s_tkeep = 8'h00;
  logic        m_len_tvalid;
  logic        m_len_tready = 1'b1;
  logic [15:0] m_len_bytes, m_len_beats;
  logic        m_len_ovf;
  logic [7:0]  drop_count;
  logic        in_msg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  msg_len_recorder #(
    .NUM_COUNT_BITS (16),
    .TKEEP_WIDTH    (8),
    .FIFO_DEPTH     (4),
    .DROP_CNT_BITS  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .s_tkeep      (s_tkeep),
    .m_len_tvalid (m_len_tvalid),
    .m_len_tready (m_len_tready),
    .m_len_bytes  (m_len_bytes),
    .m_len_beats  (m_len_beats),
    .m_len_ovf    (m_len_ovf),
    .drop_count   (drop_count),
    .in_msg       (in_msg)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Present one input cycle at the current falling edge, return at the next one.
  task automatic drive(input logic v, input logic r, input logic l, input logic [7:0] k);
    s_tvalid = v;
    s_tready = r;
    s_tlast  = l;
    s_tkeep  = k;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_rec(input string tag, input int b, input int bt, input logic o);
    check_val({tag, ".valid"}, {31'd0, m_len_tvalid}, 32'd1);
    check_val({tag, ".bytes"}, {16'd0, m_len_bytes}, b);
    check_val({tag, ".beats"}, {16'd0, m_len_beats}, bt);
    check_val({tag, ".ovf"},   {31'd0, m_len_ovf}, {31'd0, o});
  endtask

  initial begin
    logic [7:0] keeps [6];
    keeps[0] = 8'h01; keeps[1] = 8'h03; keeps[2] = 8'h07;
    keeps[3] = 8'h0F; keeps[4] = 8'h1F; keeps[5] = 8'h3F;

    repeat (2) @(negedge clk);
    check_val("rst.valid", {31'd0, m_len_tvalid}, 32'd0);
    check_val("rst.bytes", {16'd0, m_len_bytes}, 32'd0);
    check_val("rst.beats", {16'd0, m_len_beats}, 32'd0);
    check_val("rst.ovf",   {31'd0, m_len_ovf}, 32'd0);
    check_val("rst.drop",  {24'd0, drop_count}, 32'd0);
    check_val("rst.in_msg", {31'd0, in_msg}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: three-beat message
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    check_val("t1.in_msg_b1", {31'd0, in_msg}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    check_val("t1.in_msg_b2", {31'd0, in_msg}, 32'd1);
    check_val("t1.novalid",   {31'd0, m_len_tvalid}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 8'h0F);
    check_rec("t1.rec", 20, 3, 1'b0);
    check_val("t1.in_msg_end", {31'd0, in_msg}, 32'd0);
    idle();
    check_val("t1.popped", {31'd0, m_len_tvalid}, 32'd0);

    // 2: single-beat messages including a zero-byte beat
    drive(1'b1, 1'b1, 1'b1, 8'h81);
    check_rec("t2.rec0", 2, 1, 1'b0);
    check_val("t2.in_msg0", {31'd0, in_msg}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    check_rec("t2.rec1", 0, 1, 1'b0);
    check_val("t2.in_msg1", {31'd0, in_msg}, 32'd0);
    idle();

    // 3: stalled cycles (with tlast asserted) must be ignored
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    repeat (5) drive(1'b1, 1'b0, 1'b1, 8'hFF);
    check_val("t3.stall_in_msg", {31'd0, in_msg}, 32'd1);
    check_val("t3.stall_valid",  {31'd0, m_len_tvalid}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 8'h01);
    check_rec("t3.rec", 9, 2, 1'b0);
    idle();

    // 4: overflow the FIFO with the consumer stalled, then drain
    m_len_tready = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, keeps[i]);
    idle();
    idle();
    check_rec("t4.hold", 1, 1, 1'b0);
    check_val("t4.drop", {24'd0, drop_count}, 32'd2);
    m_len_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_rec($sformatf("t4.drain%0d", i), i + 1, 1, 1'b0);
      idle();
    end
    check_val("t4.empty", {31'd0, m_len_tvalid}, 32'd0);

    // 5: tlast beat coinciding with a pop while full
    m_len_tready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, keeps[i]);
    m_len_tready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'hFF);
    m_len_tready = 1'b0;
    idle();
    check_val("t5.drop", {24'd0, drop_count}, 32'd2);
    check_rec("t5.head", 2, 1, 1'b0);
    m_len_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_rec($sformatf("t5.drain%0d", i), (i < 3) ? i + 2 : 8, 1, 1'b0);
      idle();
    end
    check_val("t5.empty", {31'd0, m_len_tvalid}, 32'd0);

    // 6a: saturation of the byte count
    for (int i = 0; i < 8193; i++) drive(1'b1, 1'b1, 1'b0, 8'hFF);
    drive(1'b1, 1'b1, 1'b1, 8'hFF);
    check_rec("t6.sat", 65535, 8194, 1'b1);
    idle();

    // 6b: reset mid-message discards the partial message
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    s_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    check_val("t6.rst_in_msg", {31'd0, in_msg}, 32'd0);
    check_val("t6.rst_drop",   {24'd0, drop_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 8'h03);
    check_rec("t6.fresh", 2, 1, 1'b0);
    idle();
    check_val("t6.only_one", {31'd0, m_len_tvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
